// File: rtl/updown_counter_ctrl.sv
// updown_counter_ctrl
//   Parametrised up/down counter with run/stop and direction control.
//   Commands come from one-cycle button pulses and from ASCII bytes
//   delivered by the UART receiver. While running, the count steps once
//   every DIV = CLK_FREQ_HZ/TICK_HZ clock cycles. At a terminal value it
//   either wraps (WRAP=1) or holds and stops itself (WRAP=0).
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_STOP | prescaler frozen, count holds
//   ST_RUN  | prescaler advancing, count steps on each tick
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   btn_mode/run_stop/clear    one-cycle command pulses from button detectors
//   uart_valid, uart_data      received ASCII byte, qualified by uart_valid
//   count                      current count, 0..MAX_COUNT
//   count_tick                 one-cycle pulse on every cycle the count steps
//   led_mode                   01 = up, 10 = down
//   led_run_stop               01 = stop, 10 = run
module updown_counter_ctrl #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int MAX_COUNT   = 9999,
  parameter int CNT_W       = 14,
  parameter int WRAP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_run_stop,
  input  logic             btn_clear,
  input  logic             uart_valid,
  input  logic [7:0]       uart_data,
  output logic [CNT_W-1:0] count,
  output logic             count_tick,
  output logic [1:0]       led_mode,
  output logic [1:0]       led_run_stop
);

  localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int PSC_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  state_t           state_q, state_n;
  dir_t             dir_q, dir_n;
  logic [PSC_W-1:0] psc_q, psc_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             tick_q, tick_n;
  logic [1:0]       led_mode_q, led_mode_n;
  logic [1:0]       led_rs_q, led_rs_n;

  logic cmd_run_stop, cmd_clear, cmd_toggle, cmd_up, cmd_down;
  logic tick_due, at_term, term_stop;

  // Button pulses and UART commands are OR'd so a simultaneous pair acts once.
  always_comb begin
    cmd_run_stop = btn_run_stop;
    cmd_clear    = btn_clear;
    cmd_toggle   = btn_mode;
    cmd_up       = 1'b0;
    cmd_down     = 1'b0;
    if (uart_valid) begin
      case (uart_data)
        "r", "R": cmd_run_stop = 1'b1;
        "c", "C": cmd_clear    = 1'b1;
        "m", "M": cmd_toggle   = 1'b1;
        "u", "U": cmd_up       = 1'b1;
        "d", "D": cmd_down     = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_STOP;
      dir_q      <= DIR_UP;
      psc_q      <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      led_mode_q <= 2'b01;
      led_rs_q   <= 2'b01;
    end else begin
      state_q    <= state_n;
      dir_q      <= dir_n;
      psc_q      <= psc_n;
      count_q    <= count_n;
      tick_q     <= tick_n;
      led_mode_q <= led_mode_n;
      led_rs_q   <= led_rs_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    dir_n     = dir_q;
    psc_n     = psc_q;
    count_n   = count_q;
    tick_n    = 1'b0;
    term_stop = 1'b0;

    tick_due = (state_q == ST_RUN) && (psc_q == PSC_LAST);
    at_term  = (dir_q == DIR_UP) ? (count_q == CNT_MAX) : (count_q == '0);

    // Clear beats a coincident tick, so a terminal hit is not seen either.
    if (cmd_clear) begin
      count_n = '0;
      psc_n   = '0;
    end else if (tick_due) begin
      psc_n = '0;
      if (at_term && (WRAP == 0)) begin
        term_stop = 1'b1;
      end else begin
        tick_n = 1'b1;
        if (dir_q == DIR_UP) count_n = at_term ? '0 : count_q + CNT_ONE;
        else                 count_n = at_term ? CNT_MAX : count_q - CNT_ONE;
      end
    end else if (state_q == ST_RUN) begin
      psc_n = psc_q + PSC_W'(1);
    end

    if (term_stop)         state_n = ST_STOP;
    else if (cmd_run_stop) state_n = (state_q == ST_RUN) ? ST_STOP : ST_RUN;

    // The tick above already used dir_q; a new direction applies from the next tick.
    if (cmd_up)          dir_n = DIR_UP;
    else if (cmd_down)   dir_n = DIR_DOWN;
    else if (cmd_toggle) dir_n = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;

    led_mode_n = (dir_n == DIR_UP) ? 2'b01 : 2'b10;
    led_rs_n   = (state_n == ST_RUN) ? 2'b10 : 2'b01;
  end

  assign count        = count_q;
  assign count_tick   = tick_q;
  assign led_mode     = led_mode_q;
  assign led_run_stop = led_rs_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Bench for updown_counter_ctrl: a wrapping and a saturating instance share
// the same stimulus and are each compared every cycle against a small
// behavioural model of the counter.
module tb_updown_counter_ctrl;

  localparam int CLK_HZ = 10;
  localparam int TK_HZ  = 1;
  localparam int DIV    = CLK_HZ / TK_HZ;
  localparam int MAXC   = 5;
  localparam int CW     = 3;

  logic clk = 1'b0;
  logic reset, btn_mode, btn_run_stop, btn_clear, uart_valid;
  logic [7:0] uart_data;

  logic [CW-1:0] cnt_w, cnt_s;
  logic tick_w, tick_s;
  logic [1:0] lm_w, lm_s, lr_w, lr_s;

  int n_chk  = 0;
  int n_fail = 0;

  // model state, index 0 = wrap instance, 1 = saturating instance
  int m_cnt[2];
  int m_phase[2];
  bit m_run[2];
  bit m_up[2];
  bit m_tick[2];

  always #5 clk = ~clk;

  updown_counter_ctrl #(.CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TK_HZ), .MAX_COUNT(MAXC),
                        .CNT_W(CW), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_run_stop(btn_run_stop),
    .btn_clear(btn_clear), .uart_valid(uart_valid), .uart_data(uart_data),
    .count(cnt_w), .count_tick(tick_w), .led_mode(lm_w), .led_run_stop(lr_w));

  updown_counter_ctrl #(.CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TK_HZ), .MAX_COUNT(MAXC),
                        .CNT_W(CW), .WRAP(0)) dut_s (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_run_stop(btn_run_stop),
    .btn_clear(btn_clear), .uart_valid(uart_valid), .uart_data(uart_data),
    .count(cnt_s), .count_tick(tick_s), .led_mode(lm_s), .led_run_stop(lr_s));

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_cmd(input byte c, input byte lc);
    return uart_valid && (c == lc || c == (lc - 8'd32));
  endfunction

  // One clock of the reference behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit rs, clr, tog, fu, fd, stop_hit;
    byte c;
    c   = uart_data;
    rs  = btn_run_stop | is_cmd(c, "r");
    clr = btn_clear    | is_cmd(c, "c");
    tog = btn_mode     | is_cmd(c, "m");
    fu  = is_cmd(c, "u");
    fd  = is_cmd(c, "d");
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 1'b0;
      stop_hit  = 1'b0;
      if (reset) begin
        m_cnt[i] = 0; m_phase[i] = 0; m_run[i] = 1'b0; m_up[i] = 1'b1;
      end else begin
        if (clr) begin
          m_cnt[i] = 0; m_phase[i] = 0;
        end else if (m_run[i]) begin
          if (m_phase[i] == DIV - 1) begin
            m_phase[i] = 0;
            if (i == 1 && ((m_up[i] && m_cnt[i] == MAXC) || (!m_up[i] && m_cnt[i] == 0)))
              stop_hit = 1'b1;
            else begin
              m_tick[i] = 1'b1;
              m_cnt[i] = m_up[i] ? (m_cnt[i] + 1) % (MAXC + 1)
                                 : (m_cnt[i] + MAXC) % (MAXC + 1);
            end
          end else begin
            m_phase[i]++;
          end
        end
        if (stop_hit) m_run[i] = 1'b0;
        else if (rs)  m_run[i] = !m_run[i];
        if (fu)       m_up[i] = 1'b1;
        else if (fd)  m_up[i] = 1'b0;
        else if (tog) m_up[i] = !m_up[i];
      end
    end
  endtask

  task automatic compare_all();
    check("w_count", int'(cnt_w), m_cnt[0]);
    check("w_tick",  int'(tick_w), int'(m_tick[0]));
    check("w_led_mode", int'(lm_w), m_up[0] ? 1 : 2);
    check("w_led_run",  int'(lr_w), m_run[0] ? 2 : 1);
    check("s_count", int'(cnt_s), m_cnt[1]);
    check("s_tick",  int'(tick_s), int'(m_tick[1]));
    check("s_led_mode", int'(lm_s), m_up[1] ? 1 : 2);
    check("s_led_run",  int'(lr_s), m_run[1] ? 2 : 1);
  endtask

  task automatic cycle(input bit rst, input bit br, input bit bm, input bit bc,
                       input bit uv, input byte ud);
    reset = rst; btn_run_stop = br; btn_mode = bm; btn_clear = bc;
    uart_valid = uv; uart_data = ud;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 8'h00);
  endtask

  byte cmds[12] = '{"r", "R", "c", "C", "m", "M", "u", "U", "d", "D", "x", "?"};

  initial begin
    reset = 1'b1; btn_mode = 0; btn_run_stop = 0; btn_clear = 0;
    uart_valid = 0; uart_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_phase[i] = 0; m_run[i] = 0; m_up[i] = 1; m_tick[i] = 0;
    end
    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 0, 8'h00);
    check("rst_count", int'(cnt_w), 0);
    check("rst_leds",  int'({lm_w, lr_w}), 4'b0101);

    // start, count up through the top terminal
    cycle(0, 1, 0, 0, 0, 8'h00);
    check("run_led", int'(lr_w), 2);
    idle(10);
    check("first_step", int'(cnt_w), 1);
    idle(55);
    check("wrap_to_zero", int'(cnt_w), 0);
    check("sat_stopped",  int'(lr_s), 1);
    check("sat_held",     int'(cnt_s), MAXC);

    // force down on the wrapping instance; saturating one restarts and hits 0
    cycle(0, 0, 0, 0, 1, "d");
    check("down_led", int'(lm_w), 2);
    cycle(0, 0, 0, 0, 1, "R");
    idle(70);

    // same-type button and UART in one cycle, ignored byte, unqualified byte
    cycle(0, 1, 0, 0, 1, "R");
    idle(3);
    cycle(0, 0, 0, 0, 1, "x");
    cycle(0, 0, 0, 0, 0, "r");
    cycle(0, 0, 1, 0, 1, "u");
    idle(25);

    // clear landing on a tick-due cycle
    while (!m_run[0]) cycle(0, 1, 0, 0, 0, 8'h00);
    while (m_phase[0] != DIV - 1) idle(1);
    cycle(0, 0, 0, 1, 0, 8'h00);
    check("clr_count", int'(cnt_w), 0);
    check("clr_notick", int'(tick_w), 0);
    idle(12);

    // randomized commands
    for (int n = 0; n < 6000; n++) begin
      bit br, bm, bc, uv, rst;
      byte ud;
      rst = ($urandom_range(0, 399) == 0);
      br  = ($urandom_range(0, 39) == 0);
      bm  = ($urandom_range(0, 29) == 0);
      bc  = ($urandom_range(0, 49) == 0) || (m_phase[0] == DIV - 1 && $urandom_range(0, 7) == 0);
      uv  = ($urandom_range(0, 19) == 0);
      ud  = cmds[$urandom_range(0, 11)];
      if (br && $urandom_range(0, 1) == 1) begin uv = 1; ud = "R"; end
      cycle(rst, br, bm, bc, uv, ud);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter_ctrl.md
Name: updown_counter_ctrl

Overview:
Parametrised up/down counter core with run/stop and mode control. It accepts one-cycle command pulses from the button detectors and ASCII commands from the UART receiver. Count width, terminal value, tick rate and terminal behaviour (wrap or saturate-and-stop) are parameters. Its count output drives fndController directly, and its LED outputs go to the board.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency.
TICK_HZ, 10, count step rate while running; DIV = CLK_FREQ_HZ/TICK_HZ, must be >= 2.
MAX_COUNT, 9999, terminal value; count range is 0..MAX_COUNT.
CNT_W, 14, count width; must satisfy 2**CNT_W > MAX_COUNT.
WRAP, 1, 1 = wrap at terminals; 0 = saturate at terminal and auto-stop.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_mode  in  1  one-cycle pulse: toggle direction
btn_run_stop  in  1  one-cycle pulse: toggle run/stop
btn_clear  in  1  one-cycle pulse: clear count
uart_valid  in  1  one-cycle pulse: uart_data holds a received byte
uart_data  in  8  received ASCII byte, sampled only when uart_valid=1
count  out  CNT_W  current count value
count_tick  out  1  one-cycle pulse on every cycle in which count steps
led_mode  out  2  2'b01 = up, 2'b10 = down
led_run_stop  out  2  2'b01 = stop, 2'b10 = run

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: count=0, count_tick=0, state=STOP, dir=UP, led_mode=01, led_run_stop=01, prescaler=0.
- A reset asserted mid-run overrides everything in that cycle.
- UART decode (only when uart_valid=1):
  - 'r'/'R' = run/stop toggle; 'c'/'C' = clear; 'm'/'M' = direction toggle.
  - 'u'/'U' = force UP; 'd'/'D' = force DOWN.
  - Any other byte is ignored.
- Command merge: each button pulse is OR'd with the matching UART command. A button and a UART command of the same type in the same cycle act once; no double toggle.
- Force UP/DOWN takes priority over a direction toggle in the same cycle.
- State machine has two states, STOP and RUN:
  - STOP -> RUN on run_stop command.
  - RUN -> STOP on run_stop command, or on a terminal hit when WRAP=0.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and holds in STOP.
  - A tick is generated when the prescaler = DIV-1 in RUN; the prescaler then returns to 0.
  - A clear command zeroes the prescaler.
- Counting, on a tick:
  - UP: count+1.
  - DOWN: count-1.
  - count_tick=1 for exactly that cycle. All outputs are registered, so count and count_tick update on the clock edge after the tick condition.
- Terminals with WRAP=1: UP at MAX_COUNT -> 0; DOWN at 0 -> MAX_COUNT.
- Terminals with WRAP=0:
  - UP at MAX_COUNT: count holds, state -> STOP, no count_tick.
  - DOWN at 0: same behaviour (count holds, state -> STOP, no count_tick).
- Clear:
  - Sets count=0 and prescaler=0 in any state; state and dir are unchanged.
  - Clear in the same cycle as a tick: clear wins and count_tick=0.
- Direction toggle in the same cycle as a tick: the tick uses the old direction; the new direction applies from the next tick.
- Run/stop toggle in the same cycle as a tick: the tick is applied, then the state changes.
- Run/stop command together with a WRAP=0 terminal hit in the same cycle: final state is STOP.
- LED outputs reflect the registered state and dir, one cycle after the command.
- Count never leaves 0..MAX_COUNT.

Test Plan:
(All with CLK_FREQ_HZ=10, TICK_HZ=1 → DIV=10, MAX_COUNT=5.)
- Reset, then btn_run_stop pulse -> led_run_stop=10 next cycle; count goes 1,2,3 at 10-cycle intervals, with one count_tick pulse per step.
- WRAP=1, UP, run to count=5 -> next tick count=0. Then UART 'd' -> led_mode=10, and the ticks give 5,4.
- WRAP=0, UP, run to count=5 -> at the next tick-due cycle count stays 5, led_run_stop=01, no count_tick. DOWN from 0 behaves the same way.
- Running at count=3, btn_clear in the same cycle as the tick-due cycle -> count=0, no count_tick, still RUN; next step comes 10 cycles later.
- btn_run_stop together with uart_valid/'R' in the same cycle -> a single toggle. uart_valid with 'x' -> no change. uart_data='r' with uart_valid=0 -> no change.
- reset asserted while RUN, DOWN, count=4 -> next cycle: count=0, STOP, UP, LEDs 01/01, count_tick=0.
